regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 81 ++++++++
 tb/tb_regfile_mp.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file with a busy scoreboard. x0 reads as zero.
// Writes and reservations update state on the clock edge; reads are combinational with optional same-cycle write forwarding.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush
);

    logic [XLEN-1:0]  r_mem [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Scoreboard update order: writes clear, then flush or reserve. Reserve beats a same-cycle write.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p]) begin
                w_busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (flush) begin
            w_busy_nxt = '0;
        end else if (rsv_en) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Later ports overwrite earlier ones, so the highest-indexed write to an address wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
                    r_mem[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_en[i] && (rd_addr[i*AW +: AW] != '0)) begin
                rd_data[i*XLEN +: XLEN] = r_mem[rd_addr[i*AW +: AW]];
                rd_busy[i]              = r_busy[rd_addr[i*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW])) begin
                            rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
                            rd_busy[i]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed test of regfile_mp: a forwarding instance and a non-forwarding instance
// share one set of inputs.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_en[p]          = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en[p]              = 1'b1;
        wr_addr[p*AW +: AW]   = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    initial begin
        rst = 1'b1; rd_en = '0; rd_addr = '0; wr_data = '0; wr_addr = '0;
        rsv_addr = '0; idle();
        tick(); tick();
        rd(0, 5'd5); rd(1, 5'd9);
        #1;
        check("rst_data0", rd_data[31:0], 32'h0);
        check("rst_busy1", {31'b0, rd_busy[1]}, 32'h0);
        rst = 1'b0;

        // write x5, forwarded same cycle, readable next cycle
        wr(0, 5'd5, 32'hDEADBEEF); rd(1, 5'd5);
        #1;
        check("byp_x5", rd_data[63:32], 32'hDEADBEEF);
        check("byp_x5_busy", {31'b0, rd_busy[1]}, 32'h0);
        check("nb_x5_pre", rd_data_nb[63:32], 32'h0);
        tick(); idle(); #1;
        check("x5", rd_data[63:32], 32'hDEADBEEF);
        check("nb_x5", rd_data_nb[63:32], 32'hDEADBEEF);
        check("x5_busy", {31'b0, rd_busy[1]}, 32'h0);

        // two ports write x7, port1 wins
        wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7);
        #1;
        check("byp_x7", rd_data[31:0], 32'h22);
        tick(); idle(); #1;
        check("x7", rd_data[31:0], 32'h22);
        check("nb_x7", rd_data_nb[31:0], 32'h22);

        // disabled read port returns zero
        rd_en[0] = 1'b0; #1;
        check("rden0_data", rd_data[31:0], 32'h0);
        rd(0, 5'd9);

        // reservation / scoreboard on x9
        rsv(5'd9); #1;
        check("rsv_same_cyc", {31'b0, rd_busy[0]}, 32'h0);
        tick(); idle(); #1;
        check("rsv_busy", {31'b0, rd_busy[0]}, 32'h1);
        check("nb_rsv_busy", {31'b0, rd_busy_nb[0]}, 32'h1);
        wr(1, 5'd9, 32'h55); #1;
        check("byp_x9_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("byp_x9", rd_data[31:0], 32'h55);
        check("nb_x9_busy_pre", {31'b0, rd_busy_nb[0]}, 32'h1);
        check("nb_x9_pre", rd_data_nb[31:0], 32'h0);
        tick(); idle(); #1;
        check("x9_busy_clr", {31'b0, rd_busy[0]}, 32'h0);
        check("x9", rd_data[31:0], 32'h55);
        wr(0, 5'd9, 32'h66); rsv(5'd9);
        tick(); idle(); #1;
        check("x9_wr_rsv_busy", {31'b0, rd_busy[0]}, 32'h1);
        check("x9_wr_rsv_data", rd_data[31:0], 32'h66);

        // x0 hardwired
        wr(0, 5'd0, 32'hFFFFFFFF); rsv(5'd0); rd(0, 5'd0); #1;
        check("x0_byp", rd_data[31:0], 32'h0);
        check("x0_byp_busy", {31'b0, rd_busy[0]}, 32'h0);
        tick(); idle(); #1;
        check("x0", rd_data[31:0], 32'h0);
        check("nb_x0", rd_data_nb[31:0], 32'h0);
        check("x0_busy", {31'b0, rd_busy[0]}, 32'h0);

        // flush beats reserve, same-cycle write still commits
        rsv(5'd3); tick(); rsv(5'd4); tick(); idle();
        rd(0, 5'd3); rd(1, 5'd4); #1;
        check("x3_busy", {31'b0, rd_busy[0]}, 32'h1);
        check("x4_busy", {31'b0, rd_busy[1]}, 32'h1);
        flush = 1'b1; rsv(5'd6); wr(0, 5'd10, 32'hAB);
        tick(); idle(); #1;
        check("x3_flushed", {31'b0, rd_busy[0]}, 32'h0);
        check("x4_flushed", {31'b0, rd_busy[1]}, 32'h0);
        check("x9_flushed", {31'b0, dut.r_busy[9]}, 32'h0);
        rd(0, 5'd6); rd(1, 5'd10); #1;
        check("x6_flushed", {31'b0, rd_busy[0]}, 32'h0);
        check("nb_x6_flushed", {31'b0, rd_busy_nb[0]}, 32'h0);
        check("x10_flush_wr", rd_data[63:32], 32'hAB);

        // populate x1..x31, then reset with a write and reserve active
        for (int a = 1; a < 32; a += 2) begin
            wr(0, a[4:0], a * 32'h01010101);
            if (a + 1 < 32) wr(1, 5'(a + 1), (a + 1) * 32'h01010101);
            else wr_en[1] = 1'b0;
            tick();
        end
        idle();
        rd(0, 5'd1); rd(1, 5'd31); #1;
        check("pop_x1", rd_data[31:0], 32'h01010101);
        check("pop_x31", rd_data[63:32], 32'h1F1F1F1F);
        check("nb_pop_x31", rd_data_nb[63:32], 32'h1F1F1F1F);
        rsv(5'd20); tick(); idle();
        rst = 1'b1; wr(0, 5'd12, 32'h12345678); rsv(5'd13); flush = 1'b0;
        tick(); idle(); rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd(0, a[4:0]); rd(1, a[4:0]); #1;
            check($sformatf("rst_x%0d", a), rd_data[31:0], 32'h0);
            check($sformatf("rst_busy_x%0d", a), {30'b0, rd_busy}, 32'h0);
            check($sformatf("nb_rst_x%0d", a), rd_data_nb[63:32], 32'h0);
            check($sformatf("nb_rst_busy_x%0d", a), {30'b0, rd_busy_nb}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
